// File: rtl/arm_const.sv
// Shared SoC constants for the text-mode video RAM: screen size, colour codes, clear FSM states.
package arm_const;

  localparam int unsigned VGA_SCREEN_SIZE = 2400;

  localparam logic [23:0] COL_NEGRO = 24'h000000;
  localparam logic [23:0] COL_VERDE = 24'h00FF00;
  localparam logic [23:0] COL_ROJO  = 24'hFF0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } vram_clr_state_t;

endpackage

// File: rtl/vram_dp_if.sv
// CPU-side bus of the video RAM: word-wide access with byte enables, ready and out-of-range flag.
interface vram_dp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14
);

  logic                  we;
  logic                  re;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     a;
  logic [DATA_W-1:0]     wd;
  logic [DATA_W-1:0]     rd;
  logic                  cpu_ready;
  logic                  oob;

  modport master (
    output we, re, be, a, wd,
    input  rd, cpu_ready, oob
  );

  modport slave (
    input  we, re, be, a, wd,
    output rd, cpu_ready, oob
  );

endinterface

// File: rtl/vram_clear_fsm.sv
// Screen clear engine: walks every cell once writing a latched fill value.
// Optional VRAM_WRITE_TRACE_EN prints clear start/done (simulation only).
module vram_clear_fsm
  import arm_const::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = VGA_SCREEN_SIZE,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_we_c,
  output logic [IDX_W-1:0]  clr_idx_c,
  output logic [DATA_W-1:0] clr_data_c,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              cpu_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  vram_clr_state_t   state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          fill_d  = clr_value;
          ptr_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ptr_d = IDX_W'(ptr_q + 1'b1);
        if (ptr_q == LAST_IDX) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: status flags are registered from the next state so they track state_q exactly
  always_comb begin
    busy_d     = (state_d == CLEAR);
    done_d     = (state_d == DONE);
    ready_d    = (state_d != CLEAR);
    clr_we_c   = (state_q == CLEAR);
    clr_idx_c  = ptr_q;
    clr_data_c = fill_q;
  end

  assign clr_busy  = busy_q;
  assign clr_done  = done_q;
  assign cpu_ready = ready_q;

`ifdef VRAM_WRITE_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset_n && state_q == IDLE && clr_start)
      $display("[vram] clear start fill=%h", clr_value);
    if (reset_n && state_q == DONE)
      $display("[vram] clear done");
  end
`else
  // Trace disabled: no simulation-only logic in this build.
`endif

endmodule

// File: rtl/vram_dp.sv
// Dual-port text-mode video RAM: CPU byte-enabled port, registered video read port, clear engine.
// Optional VRAM_WRITE_TRACE_EN prints every committed CPU write (simulation only).
module vram_dp
  import arm_const::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = VGA_SCREEN_SIZE,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  vram_dp_if.slave          cpu,
  input  logic              vid_req,
  input  logic [IDX_W-1:0]  vid_idx,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WORD_W = ADDR_W - 2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we_c;
  logic [IDX_W-1:0]  clr_idx_c;
  logic [DATA_W-1:0] clr_data_c;
  logic              cpu_ready;

  logic [WORD_W-1:0] cpu_word_c;
  logic [IDX_W-1:0]  cpu_cell_c;
  logic              cpu_ok_c;
  logic              cpu_wr_c;
  logic              vid_ok_c;
  logic              unused_addr_lsb;

  logic [DATA_W-1:0] rd_q, rd_d;
  logic              oob_q, oob_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;

  vram_clear_fsm #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_clear (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_start  (clr_start),
    .clr_value  (clr_value),
    .clr_we_c   (clr_we_c),
    .clr_idx_c  (clr_idx_c),
    .clr_data_c (clr_data_c),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .cpu_ready  (cpu_ready)
  );

  assign cpu_word_c      = cpu.a[ADDR_W-1:2];
  assign cpu_cell_c      = IDX_W'(cpu_word_c);
  assign cpu_ok_c        = (32'(cpu_word_c) < DEPTH);
  assign cpu_wr_c        = cpu.we && cpu_ready && cpu_ok_c && reset_n;
  assign unused_addr_lsb = ^cpu.a[1:0];

  // Range check only needed when the index width can address past the last cell
  if ((1 << IDX_W) > DEPTH) begin : g_vid_chk
    assign vid_ok_c = (32'(vid_idx) < DEPTH);
  end else begin : g_vid_nochk
    assign vid_ok_c = 1'b1;
  end

  // Memory write port; clear and CPU never write in the same cycle since cpu_ready is low during clear
  always_ff @(posedge clk) begin
    if (clr_we_c && reset_n) begin
      mem[clr_idx_c] <= clr_data_c;
    end else if (cpu_wr_c) begin
      for (int i = 0; i < BE_W; i++) begin
        if (cpu.be[i]) mem[cpu_cell_c][i*8 +: 8] <= cpu.wd[i*8 +: 8];
      end
    end
  end

  // Read ports sample pre-write contents (read-before-write)
  always_comb begin
    rd_d        = rd_q;
    oob_d       = 1'b0;
    vid_data_d  = vid_data_q;
    vid_valid_d = vid_req;
    if (cpu.re && cpu_ready) rd_d = cpu_ok_c ? mem[cpu_cell_c] : '0;
    if (cpu_ready && (cpu.we || cpu.re) && !cpu_ok_c) oob_d = 1'b1;
    if (vid_req) vid_data_d = vid_ok_c ? mem[vid_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q        <= '0;
      oob_q       <= 1'b0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      oob_q       <= oob_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign cpu.rd        = rd_q;
  assign cpu.oob       = oob_q;
  assign cpu.cpu_ready = cpu_ready;
  assign vid_data      = vid_data_q;
  assign vid_valid     = vid_valid_q;

`ifdef VRAM_WRITE_TRACE_EN
  always_ff @(posedge clk) begin
    if (cpu_wr_c) begin
      unique case (cpu.wd[31:8])
        COL_NEGRO: $display("[vram] wr a=%h d=%h char=%c col=NEGRO", cpu.a, cpu.wd, cpu.wd[7:0]);
        COL_VERDE: $display("[vram] wr a=%h d=%h char=%c col=VERDE", cpu.a, cpu.wd, cpu.wd[7:0]);
        COL_ROJO:  $display("[vram] wr a=%h d=%h char=%c col=ROJO",  cpu.a, cpu.wd, cpu.wd[7:0]);
        default:   $display("[vram] wr a=%h d=%h char=%c col=OTRO",  cpu.a, cpu.wd, cpu.wd[7:0]);
      endcase
    end
  end
`else
  // Trace disabled: no simulation-only logic in this build.
`endif

endmodule

// File: tb/tb_vram_dp.sv
// Directed self-checking bench for vram_dp with a 16-cell screen.
module tb_vram_dp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned IDX_W  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic              vid_req;
  logic [IDX_W-1:0]  vid_idx;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              clr_start;
  logic [DATA_W-1:0] clr_value;
  logic              clr_busy;
  logic              clr_done;

  int checks = 0;
  int errors = 0;

  vram_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu       (bus.slave),
    .vid_req   (vid_req),
    .vid_idx   (vid_idx),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .clr_start (clr_start),
    .clr_value (clr_value),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  // Drive helpers: called at a negedge, return DUT outputs sampled at the following negedge
  task automatic cpu_write(input logic [ADDR_W-1:0] addr, input logic [3:0] b,
                           input logic [31:0] d, output logic o);
    bus.we = 1'b1; bus.re = 1'b0; bus.a = addr; bus.be = b; bus.wd = d;
    @(negedge clk);
    o = bus.oob;
    bus.we = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] addr, output logic [31:0] d, output logic o);
    bus.re = 1'b1; bus.we = 1'b0; bus.a = addr;
    @(negedge clk);
    d = bus.rd; o = bus.oob;
    bus.re = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.rd !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", bus.rd); end
    checks++; if (vid_data !== 32'h0) begin errors++; $display("FAIL reset_vid_data: got %h expected 0", vid_data); end
    checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL reset_vid_valid: got %b expected 0", vid_valid); end
    checks++; if (bus.oob !== 1'b0) begin errors++; $display("FAIL reset_oob: got %b expected 0", bus.oob); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", clr_done); end
    checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.cpu_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic o; logic [31:0] d;
    cpu_write(14'h8, 4'hF, 32'h00FF0041, o);
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL wr_oob: got %b expected 0", o); end
    cpu_read(14'h8, d, o);
    checks++; if (d !== 32'h00FF0041) begin errors++; $display("FAIL rd_basic: got %h expected 00ff0041", d); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL rd_oob: got %b expected 0", o); end
    @(negedge clk);
    checks++; if (bus.rd !== 32'h00FF0041) begin errors++; $display("FAIL rd_hold: got %h expected 00ff0041", bus.rd); end
  endtask

  task automatic test_partial();
    logic o; logic [31:0] d;
    cpu_write(14'hC, 4'hF, 32'hFF000041, o);
    cpu_write(14'hC, 4'b0001, 32'h0000005A, o);
    cpu_read(14'hC, d, o);
    checks++; if (d !== 32'hFF00005A) begin errors++; $display("FAIL partial_lane0: got %h expected ff00005a", d); end
    cpu_write(14'hC, 4'b0110, 32'h12345678, o);
    cpu_read(14'hC, d, o);
    checks++; if (d !== 32'hFF34565A) begin errors++; $display("FAIL partial_mid: got %h expected ff34565a", d); end
    cpu_write(14'hF, 4'b1000, 32'h77000000, o);
    cpu_read(14'hD, d, o);
    checks++; if (d !== 32'h7734565A) begin errors++; $display("FAIL addr_lsb_ignored: got %h expected 7734565a", d); end
  endtask

  task automatic test_oob();
    logic o; logic [31:0] d;
    cpu_write(14'h0, 4'hF, 32'h11111111, o);
    cpu_write(14'h40, 4'hF, 32'hDEADBEEF, o);
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL oob_wr: got %b expected 1", o); end
    @(negedge clk);
    checks++; if (bus.oob !== 1'b0) begin errors++; $display("FAIL oob_pulse: got %b expected 0", bus.oob); end
    cpu_read(14'h40, d, o);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oob_rd_data: got %h expected 0", d); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL oob_rd: got %b expected 1", o); end
    cpu_read(14'h0, d, o);
    checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL oob_wr_dropped: got %h expected 11111111", d); end
  endtask

  task automatic test_same_cycle_rw();
    logic o; logic [31:0] d;
    bus.we = 1'b1; bus.re = 1'b1; bus.a = 14'h8; bus.be = 4'hF; bus.wd = 32'hAAAA5555;
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0;
    checks++; if (bus.rd !== 32'h00FF0041) begin errors++; $display("FAIL rw_old_data: got %h expected 00ff0041", bus.rd); end
    cpu_read(14'h8, d, o);
    checks++; if (d !== 32'hAAAA5555) begin errors++; $display("FAIL rw_new_data: got %h expected aaaa5555", d); end
  endtask

  task automatic test_video();
    vid_req = 1'b1; vid_idx = 4'd2;
    @(negedge clk);
    checks++; if (vid_valid !== 1'b1) begin errors++; $display("FAIL vid_valid: got %b expected 1", vid_valid); end
    checks++; if (vid_data !== 32'hAAAA5555) begin errors++; $display("FAIL vid_data: got %h expected aaaa5555", vid_data); end
    vid_req = 1'b0; vid_idx = 4'd3;
    @(negedge clk);
    checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL vid_valid_low: got %b expected 0", vid_valid); end
    checks++; if (vid_data !== 32'hAAAA5555) begin errors++; $display("FAIL vid_hold: got %h expected aaaa5555", vid_data); end
  endtask

  task automatic test_clear();
    logic o; logic [31:0] d;
    int busy_cnt, nrdy_cnt, done_cnt, oob_cnt;
    busy_cnt = 0; nrdy_cnt = 0; done_cnt = 0; oob_cnt = 0;
    clr_start = 1'b1; clr_value = 32'h00000020;
    bus.we = 1'b1; bus.a = 14'h14; bus.be = 4'hF; bus.wd = 32'h00000055;
    @(negedge clk);
    clr_start = 1'b0; clr_value = 32'h0000FFFF; bus.we = 1'b0;
    checks++; if (clr_busy !== 1'b1 || bus.cpu_ready !== 1'b0) begin
      errors++; $display("FAIL clr_enter: got busy=%b ready=%b expected busy=1 ready=0", clr_busy, bus.cpu_ready); end
    for (int c = 0; c < 20; c++) begin
      if (clr_busy) busy_cnt++;
      if (!bus.cpu_ready) nrdy_cnt++;
      if (clr_done) done_cnt++;
      if (bus.oob) oob_cnt++;
      if (c == 4) begin
        checks++; if (vid_valid !== 1'b1 || vid_data !== 32'h7734565A) begin
          errors++; $display("FAIL vid_rbw_clear: got valid=%b data=%h expected 1 7734565a", vid_valid, vid_data); end
      end
      if (c == 5) begin
        checks++; if (vid_data !== 32'h00000020) begin
          errors++; $display("FAIL vid_after_clear: got %h expected 00000020", vid_data); end
      end
      if (c == 16) begin
        checks++; if (clr_done !== 1'b1 || clr_busy !== 1'b0 || bus.cpu_ready !== 1'b1) begin
          errors++; $display("FAIL clr_done_cycle: got done=%b busy=%b ready=%b expected 1 0 1", clr_done, clr_busy, bus.cpu_ready); end
      end
      case (c)
        3: begin vid_req = 1'b1; vid_idx = 4'd3; end
        5: begin vid_req = 1'b0; bus.we = 1'b1; bus.a = 14'h4; bus.wd = 32'hBADBAD00; end
        6: bus.a = 14'h40;
        7: bus.we = 1'b0;
        8: begin clr_start = 1'b1; clr_value = 32'h00000099; end
        9: clr_start = 1'b0;
        16: begin clr_start = 1'b1; clr_value = 32'h00000099; end
        17: clr_start = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    checks++; if (busy_cnt != 16) begin errors++; $display("FAIL clr_busy_len: got %0d expected 16", busy_cnt); end
    checks++; if (nrdy_cnt != 16) begin errors++; $display("FAIL clr_ready_len: got %0d expected 16", nrdy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (oob_cnt != 0) begin errors++; $display("FAIL clr_oob_masked: got %0d expected 0", oob_cnt); end
    for (int i = 0; i < 16; i++) begin
      cpu_read(14'(i * 4), d, o);
      checks++; if (d !== 32'h00000020) begin errors++; $display("FAIL clr_cell%0d: got %h expected 00000020", i, d); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic o; logic [31:0] d;
    int n;
    for (int i = 0; i < 16; i++) cpu_write(14'(i * 4), 4'hF, 32'h100 + 32'(i), o);
    cpu_read(14'h0, d, o);
    vid_req = 1'b1; vid_idx = 4'd1;
    @(negedge clk);
    vid_req = 1'b0;
    clr_start = 1'b1; clr_value = 32'h0000007E;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0 || bus.cpu_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state: got busy=%b done=%b ready=%b expected 0 0 1", clr_busy, clr_done, bus.cpu_ready); end
    checks++; if (bus.rd !== 32'h0 || vid_data !== 32'h0 || vid_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got rd=%h vid=%h valid=%b expected 0 0 0", bus.rd, vid_data, vid_valid); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_no_done: got done=%b busy=%b expected 0 0", clr_done, clr_busy); end
    for (int i = 0; i < 16; i++) begin
      cpu_read(14'(i * 4), d, o);
      checks++;
      if (i < 7) begin
        if (d !== 32'h0000007E) begin errors++; $display("FAIL midrst_cell%0d: got %h expected 0000007e", i, d); end
      end else begin
        if (d !== 32'h100 + 32'(i)) begin errors++; $display("FAIL midrst_cell%0d: got %h expected %h", i, d, 32'h100 + 32'(i)); end
      end
    end
    clr_start = 1'b1; clr_value = 32'h00000005;
    @(negedge clk);
    clr_start = 1'b0;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", clr_busy); end
    n = 0;
    while (clr_done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b expected 1 (timeout)", clr_done); end
    @(negedge clk);
    cpu_read(14'h0, d, o);
    checks++; if (d !== 32'h00000005) begin errors++; $display("FAIL restart_cell0: got %h expected 00000005", d); end
    cpu_read(14'h3C, d, o);
    checks++; if (d !== 32'h00000005) begin errors++; $display("FAIL restart_cell15: got %h expected 00000005", d); end
  endtask

  initial begin
    bus.we = 1'b0; bus.re = 1'b0; bus.be = 4'h0; bus.a = '0; bus.wd = '0;
    vid_req = 1'b0; vid_idx = '0; clr_start = 1'b0; clr_value = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_partial();
    test_oob();
    test_same_cycle_rw();
    test_video();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
